// File: rtl/time_set_ctrl_pkg.sv
// rtl/time_set_ctrl_pkg.sv - shared field encodings, state type and default timing for the clock setting logic
package time_set_ctrl_pkg;

   localparam logic [2:0] FIELD_RUN   = 3'd0;
   localparam logic [2:0] FIELD_HOUR  = 3'd1;
   localparam logic [2:0] FIELD_MIN   = 3'd2;
   localparam logic [2:0] FIELD_SEC   = 3'd3;
   localparam logic [2:0] FIELD_DAY   = 3'd4;
   localparam logic [2:0] FIELD_MONTH = 3'd5;
   localparam logic [2:0] FIELD_YEAR  = 3'd6;

   localparam int HOLD_TICKS_DEF    = 3;
   localparam int TIMEOUT_TICKS_DEF = 30;

   // State codes equal the field_sel encodings so the state register drives field_sel directly.
   typedef enum logic [2:0] {
      ST_RUN   = FIELD_RUN,
      ST_HOUR  = FIELD_HOUR,
      ST_MIN   = FIELD_MIN,
      ST_SEC   = FIELD_SEC,
      ST_DAY   = FIELD_DAY,
      ST_MONTH = FIELD_MONTH,
      ST_YEAR  = FIELD_YEAR
   } set_state_t;

   function automatic set_state_t next_field(input set_state_t s);
      case (s)
         ST_RUN:   return ST_HOUR;
         ST_HOUR:  return ST_MIN;
         ST_MIN:   return ST_SEC;
         ST_SEC:   return ST_DAY;
         ST_DAY:   return ST_MONTH;
         ST_MONTH: return ST_YEAR;
         default:  return ST_RUN;
      endcase
   endfunction

endpackage

// File: rtl/time_set_ctrl_btn_edge_rpt.sv
// rtl/time_set_ctrl_btn_edge_rpt.sv - rising-edge detect with hold counter and auto-repeat for a button
module time_set_ctrl_btn_edge_rpt
   import time_set_ctrl_pkg::*;
#(
   parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   input  logic enable,
   output logic fire
);

   localparam int                HOLD_W   = $clog2(HOLD_TICKS + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

   logic              btn_q;
   logic              counting;
   logic [HOLD_W-1:0] hold_cnt;

   assign counting = btn & enable;
   // First strobe comes from the edge; repeats once the pre-update count has saturated.
   assign fire     = counting & (~btn_q | (hold_cnt == HOLD_MAX));

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_q    <= 1'b1;
         hold_cnt <= '0;
      end else begin
         btn_q <= btn;
         if (!counting)
            hold_cnt <= '0;
         else if (hold_cnt != HOLD_MAX)
            hold_cnt <= hold_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - front-panel field setting controller: mode sequencing, increment strobes, timeout, blink
module time_set_ctrl
   import time_set_ctrl_pkg::*;
#(
   parameter int HOLD_TICKS    = HOLD_TICKS_DEF,
   parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
   input  logic       sig_1Hz,
   input  logic       reset,
   input  logic       mode_b,
   input  logic       inc_b,
   output logic       run_en,
   output logic [2:0] field_sel,
   output logic       hour_b,
   output logic       min_b,
   output logic       sec_b,
   output logic       day_b,
   output logic       month_b,
   output logic       year_b,
   output logic       blink
);

   localparam int                IDLE_W    = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_TICKS - 1);

   set_state_t        state, state_nxt;
   logic              mode_q;
   logic              mode_edge;
   logic              in_set;
   logic              idle;
   logic              inc_fire;
   logic              blink_nxt;
   logic [IDLE_W-1:0] idle_cnt, idle_nxt;
   logic [5:0]        strobe, strobe_nxt;

   assign mode_edge = mode_b & ~mode_q;
   assign in_set    = (state != ST_RUN);
   assign idle      = ~mode_b & ~inc_b;

   // A mode edge in the same cycle suppresses the strobe and clears the hold count.
   time_set_ctrl_btn_edge_rpt #(
      .HOLD_TICKS(HOLD_TICKS)
   ) u_inc_rpt (
      .clk   (sig_1Hz),
      .reset (reset),
      .btn   (inc_b),
      .enable(in_set & ~mode_edge),
      .fire  (inc_fire)
   );

   always_comb begin
      state_nxt  = state;
      idle_nxt   = '0;
      strobe_nxt = '0;
      blink_nxt  = 1'b0;

      if (mode_edge)
         state_nxt = next_field(state);
      else if (in_set && idle) begin
         if (idle_cnt == IDLE_LAST)
            state_nxt = ST_RUN;
         else
            idle_nxt = idle_cnt + 1'b1;
      end

      if (inc_fire) begin
         case (state)
            ST_HOUR:  strobe_nxt[0] = 1'b1;
            ST_MIN:   strobe_nxt[1] = 1'b1;
            ST_SEC:   strobe_nxt[2] = 1'b1;
            ST_DAY:   strobe_nxt[3] = 1'b1;
            ST_MONTH: strobe_nxt[4] = 1'b1;
            ST_YEAR:  strobe_nxt[5] = 1'b1;
            default:  strobe_nxt    = '0;
         endcase
      end

      if (state_nxt == ST_RUN)
         blink_nxt = 1'b0;
      else if (!in_set)
         blink_nxt = 1'b1;
      else
         blink_nxt = ~blink;
   end

   always_ff @(posedge sig_1Hz) begin
      if (reset) begin
         state    <= ST_RUN;
         mode_q   <= 1'b1;
         idle_cnt <= '0;
         strobe   <= '0;
         blink    <= 1'b0;
         run_en   <= 1'b1;
      end else begin
         state    <= state_nxt;
         mode_q   <= mode_b;
         idle_cnt <= idle_nxt;
         strobe   <= strobe_nxt;
         blink    <= blink_nxt;
         run_en   <= (state_nxt == ST_RUN);
      end
   end

   assign field_sel = state;
   assign {year_b, month_b, day_b, sec_b, min_b, hour_b} = strobe;

endmodule
